stream_buffer: RTL
==================

Name: stream_buffer

Overview:
- Parametrised elastic buffer between two valid/ready channels of interface `bar`: consumer side on modport `bar.in` (x), producer side on modport `bar.out` (y).
- Successor to plain modport pass-through: adds configurable data width and depth, registered backpressure, occupancy reporting and synchronous flush.
- Inserted wherever a `bar` link crosses a timing boundary or needs rate decoupling.

Parameters:
- WIDTH, 32, bit width of `bar.data` (interface instantiated as `bar #(WIDTH)`).
- DEPTH, 4, number of storage entries; power of two, ≥2.
- CW, $clog2(DEPTH)+1, width of the count output; derived, not overridable.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stored entries.
- x.data  input  WIDTH  incoming payload (x is `bar.in`).
- x.valid  input  1  incoming payload valid.
- x.ready  output  1  buffer can accept; registered.
- y.data  output  WIDTH  outgoing payload (y is `bar.out`).
- y.valid  output  1  outgoing payload valid; registered.
- y.ready  input  1  downstream accepts.
- count  output  CW  entries currently stored, 0..DEPTH.

Behaviour:
- Reset (rst=1, asynchronous):
  - count=0, y.valid=0, x.ready=1.
  - y.data=0, read and write pointers=0.
  - Storage array contents are not reset.
  - Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- Handshake rules:
  - A push occurs when x.valid && x.ready at a rising edge.
  - A pop occurs when y.valid && y.ready at a rising edge.
  - Data is transferred only on a push or a pop; x.data is ignored otherwise.
- Latency:
  - A push into an empty buffer makes y.valid=1 on the next cycle, with y.data equal to the pushed word.
  - No combinational path from x to y, and none from y.ready to x.ready.
- Ordering: strict FIFO, with no loss and no duplication.
- Pointers: write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; both pointers advance.
- Full (count==DEPTH):
  - x.ready=0; x.valid is ignored.
  - A pop in a cycle where count==DEPTH raises x.ready on the next cycle. No same-cycle passthrough when full.
- Empty (count==0):
  - y.valid=0; y.ready is ignored.
  - A push while empty is never popped in the same cycle.
- Registered outputs:
  - x.ready is registered as (next count < DEPTH).
  - y.valid is registered as (next count > 0).
  - y.data is a registered copy of the entry at the next read pointer (or of x.data when the buffer goes from empty to non-empty).
- Flush (flush=1 at an edge):
  - Next state is count=0, pointers=0, y.valid=0, x.ready=1.
  - A push or pop in the same cycle is discarded; flush has priority over both.
- Stability: while y.valid=1 && y.ready=0, y.data and y.valid hold steady (AXI-style stability).
- Recommended state machine (count and pointers remain the authoritative state):
  - Encoding: EMPTY, PARTIAL, FULL.
  - EMPTY→PARTIAL on push.
  - PARTIAL→EMPTY on pop-only when count==1.
  - PARTIAL→FULL on push-only when count==DEPTH-1.
  - FULL→PARTIAL on pop.
  - Any state →EMPTY on flush.

Decomposition:
- Package `stream_pkg`:
  - localparam default WIDTH=32.
  - function cnt_width(depth) returning $clog2(depth)+1.
  - typedef enum {EMPTY, PARTIAL, FULL} stream_state_t.
- Interface `bar` is parametrised by WIDTH with modports in/out (input data/valid, output ready; and the mirror).
- One sub-module, `stream_buffer_mem`:
  - DEPTH×WIDTH register array.
  - One write port (we, waddr, wdata).
  - One combinational read port (raddr → rdata).
  - No reset on the array.
- Top level holds pointers, count, state and the output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 3 entries stored → count=0, y.valid=0, x.ready=1 immediately; the next push of 0xA5A5_0001 appears alone on y.
- Fill/drain: hold y.ready=0 and push 0x1,0x2,0x3,0x4 (DEPTH=4) → count=4, x.ready=0 on the cycle after the 4th push, and a 5th word 0x5 is not accepted; then y.ready=1 → pops 0x1..0x4 in order, y.valid=0 after the 4th.
- Full throughput: x.valid=1 and y.ready=1 continuously with an incrementing counter 0..99 → after 1 cycle of latency y emits 0..99 back-to-back and count stays at 1.
- Simultaneous push/pop at full: count=4 with push and pop in the same cycle → push is rejected (x.ready=0), pop succeeds, count=3, x.ready=1 next cycle.
- Wrap-around: push/pop 10 words with random y.ready stalls (DEPTH=4) → pointers wrap twice, output sequence identical to input, count never exceeds 4.
- Flush: with count=3, assert flush while x.valid=1 and y.ready=1 → next cycle count=0, y.valid=0, x.ready=1; neither word transferred.
- Parameter sweep: WIDTH=8, DEPTH=2 and WIDTH=64, DEPTH=16 → fill/drain and wrap scenarios pass; count width is 2 and 5 respectively.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream_buffer elastic buffer.
package stream_pkg;

  localparam int DEF_WIDTH = 32;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } stream_state_t;

endpackage

// File: rtl/bar.sv
// Valid/ready link carrying a WIDTH-bit payload; "in" is the receiving side.
interface bar #(
  parameter int WIDTH = stream_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport in  (input data, input valid, output ready);
  modport out (output data, output valid, input ready);
endinterface

// File: rtl/stream_buffer_mem.sv
// Storage array for stream_buffer: one write port, asynchronous read, no reset.
module stream_buffer_mem #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_buffer.sv
// Elastic FIFO between two bar links with registered ready/valid/data,
// occupancy count and synchronous flush.
//
//   state   | meaning
//   EMPTY   | no entries stored, y.valid low
//   PARTIAL | 1..DEPTH-1 entries stored
//   FULL    | DEPTH entries stored, x.ready low
module stream_buffer
  import stream_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = 4,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  bar.in                x,
  bar.out               y,
  output logic [CW-1:0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wptr, rptr, rptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic             push, pop;
  logic             x_ready, y_valid;
  logic [WIDTH-1:0] y_data, y_data_nxt, rdata;
  stream_state_t    state;

  assign push     = x.valid && x_ready;
  assign pop      = y_valid && y.ready;
  assign rptr_nxt = pop ? rptr + AW'(1) : rptr;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // The new head is still in flight from x when it lands on the slot being written.
  assign y_data_nxt = (push && (rptr_nxt == wptr)) ? x.data : rdata;

  stream_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wptr),
    .wdata (x.data),
    .raddr (rptr_nxt),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      x_ready <= 1'b1;
      y_valid <= 1'b0;
      y_data  <= '0;
      state   <= EMPTY;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      x_ready <= 1'b1;
      y_valid <= 1'b0;
      state   <= EMPTY;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      rptr    <= rptr_nxt;
      count   <= count_nxt;
      x_ready <= (count_nxt < FULL_CNT);
      y_valid <= (count_nxt != '0);
      if (push || pop) y_data <= y_data_nxt;
      case (state)
        EMPTY:   if (push) state <= PARTIAL;
        PARTIAL: begin
          if (pop && !push && count == CW'(1))
            state <= EMPTY;
          else if (push && !pop && count == FULL_CNT - CW'(1))
            state <= FULL;
        end
        FULL:    if (pop) state <= PARTIAL;
        default: state <= EMPTY;
      endcase
    end
  end

  assign x.ready = x_ready;
  assign y.valid = y_valid;
  assign y.data  = y_data;

endmodule
